// File: rtl/des_uart_ctrl.sv
// Command sequencer between the UART byte stream and the DES core: collects key/data
// frames, launches DES operations, streams results back out and drives the status LEDs.
module des_uart_ctrl #(
  parameter int TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_start,
  input  logic        tx_busy,
  output logic [63:0] des_key,
  output logic [63:0] des_data,
  output logic        des_decrypt,
  output logic        des_start,
  input  logic [63:0] des_result,
  input  logic        des_done,
  output logic [3:0]  status
);

  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RX      = 3'd1;
  localparam logic [2:0] S_DSTART  = 3'd2;
  localparam logic [2:0] S_DWAIT   = 3'd3;
  localparam logic [2:0] S_TXLOAD  = 3'd4;
  localparam logic [2:0] S_TXWAIT  = 3'd5;

  localparam logic [7:0] CMD_K = 8'h4B;
  localparam logic [7:0] CMD_E = 8'h45;
  localparam logic [7:0] CMD_D = 8'h44;
  localparam logic [7:0] ACK   = 8'h06;
  localparam logic [7:0] NAK   = 8'hEE;

  logic [2:0]    state_q, state_d;
  logic [7:0]    cmd_q, cmd_d;
  logic [2:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [63:0]   shift_q, shift_d;
  logic [63:0]   key_q, key_d;
  logic [63:0]   data_q, data_d;
  logic          dec_q, dec_d;
  logic          dstart_q, dstart_d;
  logic [7:0]    txd_q, txd_d;
  logic          txs_q, txs_d;
  logic [63:0]   txbuf_q, txbuf_d;
  logic [3:0]    txrem_q, txrem_d;
  logic          skip_q, skip_d;
  logic          kv_q, kv_d;
  logic          err_q, err_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    state_d  = state_q;
    cmd_d    = cmd_q;
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
    shift_d  = shift_q;
    key_d    = key_q;
    data_d   = data_q;
    dec_d    = dec_q;
    dstart_d = 1'b0;
    txd_d    = txd_q;
    txs_d    = 1'b0;
    txbuf_d  = txbuf_q;
    txrem_d  = txrem_q;
    skip_d   = skip_q;
    kv_d     = kv_q;
    err_d    = err_q;
    ovf_d    = ovf_q;

    // Bytes arriving while the engine or transmitter is busy are lost.
    if (rx_valid && (state_q == S_DSTART || state_q == S_DWAIT ||
                     state_q == S_TXLOAD || state_q == S_TXWAIT)) begin
      ovf_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_K || rx_data == CMD_E || rx_data == CMD_D) begin
            cmd_d   = rx_data;
            cnt_d   = 3'd0;
            tmo_d   = '0;
            err_d   = 1'b0;
            ovf_d   = 1'b0;
            state_d = S_RX;
          end else begin
            err_d = 1'b1;
          end
        end
      end

      S_RX: begin
        if (rx_valid) begin
          shift_d = {shift_q[55:0], rx_data};
          cnt_d   = cnt_q + 3'd1;
          tmo_d   = '0;
          if (cnt_q == 3'd7) begin
            if (cmd_q == CMD_K) begin
              key_d   = shift_d;
              kv_d    = 1'b1;
              txbuf_d = {ACK, 56'h0};
              txrem_d = 4'd1;
              state_d = S_TXLOAD;
            end else if (kv_q) begin
              data_d  = shift_d;
              dec_d   = (cmd_q == CMD_D);
              state_d = S_DSTART;
            end else begin
              err_d   = 1'b1;
              txbuf_d = {NAK, 56'h0};
              txrem_d = 4'd1;
              state_d = S_TXLOAD;
            end
          end
        end else if (tmo_q == TW'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      S_DSTART: begin
        dstart_d = 1'b1;
        state_d  = S_DWAIT;
      end

      S_DWAIT: begin
        if (des_done) begin
          txbuf_d = des_result;
          txrem_d = 4'd8;
          state_d = S_TXLOAD;
        end
      end

      S_TXLOAD: begin
        if (!tx_busy) begin
          txd_d   = txbuf_q[63:56];
          txbuf_d = {txbuf_q[55:0], 8'h0};
          txrem_d = txrem_q - 4'd1;
          txs_d   = 1'b1;
          skip_d  = 1'b1;
          state_d = S_TXWAIT;
        end
      end

      // tx_busy only rises the cycle after tx_start, so the first cycle here is ignored.
      S_TXWAIT: begin
        if (skip_q) begin
          skip_d = 1'b0;
        end else if (!tx_busy) begin
          state_d = (txrem_q != 4'd0) ? S_TXLOAD : S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cmd_q    <= 8'h0;
      cnt_q    <= 3'd0;
      tmo_q    <= '0;
      shift_q  <= 64'h0;
      key_q    <= 64'h0;
      data_q   <= 64'h0;
      dec_q    <= 1'b0;
      dstart_q <= 1'b0;
      txd_q    <= 8'h0;
      txs_q    <= 1'b0;
      txbuf_q  <= 64'h0;
      txrem_q  <= 4'd0;
      skip_q   <= 1'b0;
      kv_q     <= 1'b0;
      err_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
      shift_q  <= shift_d;
      key_q    <= key_d;
      data_q   <= data_d;
      dec_q    <= dec_d;
      dstart_q <= dstart_d;
      txd_q    <= txd_d;
      txs_q    <= txs_d;
      txbuf_q  <= txbuf_d;
      txrem_q  <= txrem_d;
      skip_q   <= skip_d;
      kv_q     <= kv_d;
      err_q    <= err_d;
      ovf_q    <= ovf_d;
    end
  end

  assign tx_data     = txd_q;
  assign tx_start    = txs_q;
  assign des_key     = key_q;
  assign des_data    = data_q;
  assign des_decrypt = dec_q;
  assign des_start   = dstart_q;
  assign status      = {ovf_q, err_q, (state_q != S_IDLE), kv_q};

endmodule

// File: tb/tb_des_uart_ctrl.sv
// Bench for des_uart_ctrl: UART and DES stubs, a frame-level reference model,
// a table of directed frames, hand sequences for corner cases and random frames.
module tb_des_uart_ctrl;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic [63:0] des_key;
  logic [63:0] des_data;
  logic        des_decrypt;
  logic        des_start;
  logic [63:0] des_result;
  logic        des_done;
  logic [3:0]  status;

  always #5 clk = ~clk;

  des_uart_ctrl #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_start(tx_start), .tx_busy(tx_busy),
    .des_key(des_key), .des_data(des_data), .des_decrypt(des_decrypt),
    .des_start(des_start), .des_result(des_result), .des_done(des_done),
    .status(status)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rx_cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // UART transmitter stub
  logic [7:0] txq[$];
  int         tx_cycs[$];
  int         last_tx_cyc = -100;
  int         busy_len = 3;
  int         busy_left = 0;
  bit         busy_pend = 1'b0;
  logic [7:0] held = 8'h0;

  initial begin
    tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (tx_busy) chk("tx_data_hold", 64'(tx_data), 64'(held));
      if (rst) held = 8'h0;
      if (tx_start) begin
        chk("tx_start_while_busy", 64'(tx_busy), 64'(0));
        chk("tx_start_spacing", 64'(cyc - last_tx_cyc >= 3), 64'(1));
        txq.push_back(tx_data);
        tx_cycs.push_back(cyc);
        last_tx_cyc = cyc;
        held = tx_data;
      end
      if (busy_pend) begin
        busy_pend = 1'b0;
        tx_busy   = 1'b1;
        busy_left = busy_len;
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) tx_busy = 1'b0;
      end
      if (tx_start) busy_pend = 1'b1;
    end
  end

  // DES core stub: result = data ^ key, 16 cycles after start
  int          n_start = 0;
  int          start_cyc = 0;
  int          done_cyc = 0;
  int          des_left = 0;
  logic [63:0] cap_key = 64'h0;
  logic [63:0] cap_data = 64'h0;

  initial begin
    des_done   = 1'b0;
    des_result = 64'h0;
    forever begin
      @(negedge clk);
      des_done = 1'b0;
      if (des_left > 0) begin
        chk("des_key_stable", des_key, cap_key);
        chk("des_data_stable", des_data, cap_data);
        des_left--;
        if (des_left == 0) begin
          des_done   = 1'b1;
          des_result = cap_key ^ cap_data;
          done_cyc   = cyc;
        end
      end
      if (des_start) begin
        n_start++;
        start_cyc = cyc;
        cap_key   = des_key;
        cap_data  = des_data;
        des_left  = 16;
      end
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Frame-level reference model
  logic [63:0] m_key = 64'h0;
  logic        m_kv = 1'b0;
  logic        m_err = 1'b0;
  logic        m_ovf = 1'b0;
  logic [7:0]  exp_tx[$];
  int          exp_start = 0;
  logic        exp_dec = 1'b0;

  task automatic model_frame(input logic [7:0] cmd, input logic [63:0] pl);
    logic [63:0] r;
    exp_tx.delete();
    exp_start = 0;
    exp_dec   = 1'b0;
    m_err     = 1'b0;
    m_ovf     = 1'b0;
    if (cmd == 8'h4B) begin
      m_key = pl;
      m_kv  = 1'b1;
      exp_tx.push_back(8'h06);
    end else if (!m_kv) begin
      m_err = 1'b1;
      exp_tx.push_back(8'hEE);
    end else begin
      r = pl ^ m_key;
      exp_start = 1;
      exp_dec   = (cmd == 8'h44);
      for (int i = 7; i >= 0; i--) exp_tx.push_back(r[i*8 +: 8]);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data     = b;
    rx_valid    = 1'b1;
    last_rx_cyc = cyc;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] cmd, input logic [63:0] pl,
                            input int maxgap, input int biggap);
    send_byte(cmd);
    for (int i = 7; i >= 0; i--) begin
      if (i == 4 && biggap > 0) tick(biggap);
      else tick(int'($urandom_range(maxgap, 0)));
      send_byte(pl[i*8 +: 8]);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (status[1] && n < budget) begin
      tick(1);
      n++;
    end
    chk("idle_reached", 64'(status[1]), 64'(0));
  endtask

  task automatic clear_obs();
    txq.delete();
    tx_cycs.delete();
    n_start = 0;
  endtask

  task automatic check_frame(input string tag);
    chk({tag, "_ntx"}, 64'(txq.size()), 64'(exp_tx.size()));
    for (int i = 0; i < exp_tx.size(); i++)
      if (i < txq.size()) chk({tag, "_txbyte"}, 64'(txq[i]), 64'(exp_tx[i]));
    chk({tag, "_status"}, 64'(status), 64'({m_ovf, m_err, 1'b0, m_kv}));
    chk({tag, "_nstart"}, 64'(n_start), 64'(exp_start));
    if (exp_start != 0) chk({tag, "_decrypt"}, 64'(des_decrypt), 64'(exp_dec));
    chk({tag, "_key"}, des_key, m_key);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_tx_data"}, 64'(tx_data), 64'(0));
    chk({tag, "_tx_start"}, 64'(tx_start), 64'(0));
    chk({tag, "_des_key"}, des_key, 64'h0);
    chk({tag, "_des_data"}, des_data, 64'h0);
    chk({tag, "_des_decrypt"}, 64'(des_decrypt), 64'(0));
    chk({tag, "_des_start"}, 64'(des_start), 64'(0));
    chk({tag, "_status"}, 64'(status), 64'(0));
  endtask

  typedef struct {
    logic [7:0]  cmd;
    logic [63:0] pl;
    int          ntx;
    logic [63:0] tx;
    logic [3:0]  st;
    int          nst;
    logic        dec;
    logic [63:0] key;
  } vec_t;

  vec_t vt[5];

  initial begin
    logic [63:0] acc;
    logic [63:0] pl;
    logic [7:0]  b;
    int          n;
    int          r;

    vt[0] = '{8'h44, 64'h1122334455667788, 1, 64'hEE, 4'b0100, 0, 1'b0, 64'h0};
    vt[1] = '{8'h4B, 64'h0123456789ABCDEF, 1, 64'h06, 4'b0001, 0, 1'b0, 64'h0123456789ABCDEF};
    vt[2] = '{8'h45, 64'h636F6D7075746572, 8, 64'h624C2817FCDFA89D, 4'b0001, 1, 1'b0, 64'h0123456789ABCDEF};
    vt[3] = '{8'h44, 64'h624C2817FCDFA89D, 8, 64'h636F6D7075746572, 4'b0001, 1, 1'b1, 64'h0123456789ABCDEF};
    vt[4] = '{8'h4B, 64'hFFFF0000AAAA5555, 1, 64'h06, 4'b0001, 0, 1'b0, 64'hFFFF0000AAAA5555};

    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h0;
    tick(3);
    rst = 1'b0;
    tick(1);
    check_reset_outputs("reset");

    // Directed frame table
    for (int k = 0; k < 5; k++) begin
      clear_obs();
      model_frame(vt[k].cmd, vt[k].pl);
      send_frame(vt[k].cmd, vt[k].pl, 0, 0);
      if (vt[k].cmd == 8'h4B) chk("vec_key_at_n1", des_key, vt[k].key);
      wait_idle(300);
      acc = 64'h0;
      foreach (txq[i]) acc = {acc[55:0], txq[i]};
      chk("vec_ntx", 64'(txq.size()), 64'(vt[k].ntx));
      chk("vec_tx", acc, vt[k].tx);
      chk("vec_status", 64'(status), 64'(vt[k].st));
      chk("vec_nstart", 64'(n_start), 64'(vt[k].nst));
      chk("vec_key", des_key, vt[k].key);
      if (vt[k].nst > 0) begin
        chk("vec_decrypt", 64'(des_decrypt), 64'(vt[k].dec));
        chk("vec_start_latency", 64'(start_cyc - last_rx_cyc), 64'(2));
        if (tx_cycs.size() > 0) chk("vec_done_to_tx", 64'(tx_cycs[0] - done_cyc), 64'(2));
      end else if (tx_cycs.size() > 0) begin
        chk("vec_tx_latency", 64'(tx_cycs[0] - last_rx_cyc), 64'(2));
      end
    end

    // Illegal command, then a normal key frame
    clear_obs();
    send_byte(8'h41);
    m_err = 1'b1;
    tick(5);
    chk("illegal_status", 64'(status), 64'({m_ovf, m_err, 1'b0, m_kv}));
    chk("illegal_ntx", 64'(txq.size()), 64'(0));
    clear_obs();
    model_frame(8'h4B, 64'h0123456789ABCDEF);
    send_frame(8'h4B, 64'h0123456789ABCDEF, 1, 0);
    wait_idle(300);
    check_frame("after_illegal");

    // Payload timeout
    clear_obs();
    send_byte(8'h45);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    tick(150);
    m_err = 1'b1;
    chk("timeout_status", 64'(status), 64'({m_ovf, m_err, 1'b0, m_kv}));
    chk("timeout_nstart", 64'(n_start), 64'(0));
    chk("timeout_ntx", 64'(txq.size()), 64'(0));
    chk("timeout_key", des_key, m_key);
    clear_obs();
    pl = {$urandom, $urandom};
    model_frame(8'h45, pl);
    send_frame(8'h45, pl, 0, 90);
    wait_idle(400);
    check_frame("after_timeout");

    // Extra byte while DES is running
    clear_obs();
    pl = {$urandom, $urandom};
    model_frame(8'h44, pl);
    send_frame(8'h44, pl, 0, 0);
    tick(3);
    send_byte(8'h5A);
    m_ovf = 1'b1;
    wait_idle(400);
    check_frame("overflow");

    // Reset during TX_WAIT
    clear_obs();
    pl = {$urandom, $urandom};
    model_frame(8'h45, pl);
    send_frame(8'h45, pl, 0, 0);
    n = 0;
    while (txq.size() == 0 && n < 100) begin
      tick(1);
      n++;
    end
    chk("rst_mid_first_tx_seen", 64'(txq.size()), 64'(1));
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    check_reset_outputs("rst_mid");
    n = txq.size();
    tick(60);
    chk("rst_mid_no_more_tx", 64'(txq.size()), 64'(n));
    m_key = 64'h0;
    m_kv  = 1'b0;
    m_err = 1'b0;
    m_ovf = 1'b0;

    // Random frames against the model
    for (int it = 0; it < 40; it++) begin
      clear_obs();
      busy_len = int'($urandom_range(5, 1));
      r = int'($urandom_range(9, 0));
      if (r == 0) begin
        b = 8'($urandom_range(255, 0));
        if (b == 8'h4B || b == 8'h45 || b == 8'h44) b = 8'h00;
        send_byte(b);
        m_err = 1'b1;
        tick(3);
        chk("rand_illegal_status", 64'(status), 64'({m_ovf, m_err, 1'b0, m_kv}));
        chk("rand_illegal_ntx", 64'(txq.size()), 64'(0));
      end else begin
        b  = (r <= 3) ? 8'h4B : (r <= 6) ? 8'h45 : 8'h44;
        pl = {$urandom, $urandom};
        model_frame(b, pl);
        send_frame(b, pl, 3, 0);
        wait_idle(600);
        check_frame("rand");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/des_uart_ctrl.md
# des_uart_ctrl

Command sequencer between the UART byte receiver/transmitter and the DES core. It collects a 64-bit key and 64-bit data blocks from the received byte stream and launches encrypt or decrypt operations on the DES core. It then streams each 64-bit result back out through the UART transmitter. It holds the only copy of the active key and reports progress on the four board status LEDs.

## Interface
Parameters:
- `TIMEOUT`, default 50000: max clk cycles allowed between payload bytes before the frame is abandoned.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `rx_data`  in  8  received byte; valid only when `rx_valid`=1.
- `rx_valid`  in  1  one-cycle strobe, one per received byte.
- `tx_data`  out  8  byte to transmit; held stable from `tx_start` until `tx_busy` falls.
- `tx_start`  out  1  one-cycle request to transmit `tx_data`.
- `tx_busy`  in  1  transmitter busy; rises the cycle after `tx_start`.
- `des_key`  out  64  key to the DES core.
- `des_data`  out  64  input block to the DES core.
- `des_decrypt`  out  1  1 = decrypt, 0 = encrypt.
- `des_start`  out  1  one-cycle start strobe to the DES core.
- `des_result`  in  64  DES output; valid when `des_done`=1.
- `des_done`  in  1  one-cycle completion strobe.
- `status`  out  4  bit 0 key_valid; bit 1 busy; bit 2 error (sticky); bit 3 overflow (sticky).

## Operation
- Frame format: one command byte followed by 8 payload bytes, MSB byte first.
  - 0x4B 'K': load key.
  - 0x45 'E': encrypt.
  - 0x44 'D': decrypt.
- States: IDLE, RX_PAYLOAD, DES_START, DES_WAIT, TX_LOAD, TX_WAIT.
- IDLE:
  - On `rx_valid` with a legal command: latch the command, clear the byte counter, clear status[2] and status[3], go to RX_PAYLOAD.
  - Any other byte: set status[2] and stay in IDLE.
- RX_PAYLOAD: each `rx_valid` shifts the byte into a 64-bit shift register (new byte enters bits [7:0]) and increments the 3-bit counter. When the 8th byte arrives:
  - 'K': copy the shift register to `des_key`, set key_valid, queue the single ack byte 0x06, go to TX_LOAD.
  - 'E'/'D' with key_valid=1: copy to `des_data`, set `des_decrypt` (1 for 'D'), go to DES_START.
  - 'E'/'D' with key_valid=0: set status[2], queue the single byte 0xEE, go to TX_LOAD.
- DES_START: pulse `des_start` for one cycle, go to DES_WAIT.
- DES_WAIT: on `des_done`, latch `des_result` into the tx buffer, queue 8 bytes, go to TX_LOAD.
- TX_LOAD:
  - If `tx_busy`=0: drive the next byte (MSB first) on `tx_data`, pulse `tx_start`, go to TX_WAIT.
  - Otherwise hold.
- TX_WAIT: skip one cycle, then wait for `tx_busy`=0.
  - Bytes remaining: go to TX_LOAD.
  - Otherwise: go to IDLE.
- `rx_valid` in DES_START, DES_WAIT, TX_LOAD or TX_WAIT: the byte is dropped and status[3] is set.
- Payload timeout: a cycle counter clears on each `rx_valid` in RX_PAYLOAD. At count = `TIMEOUT` the partial frame is discarded, status[2] is set, and the FSM returns to IDLE. No tx output and no key change.
- status[1] = (state != IDLE).
- `des_key`, `des_data` and `des_decrypt` change only at the transitions listed above. They are stable throughout DES_WAIT.

## Timing
- Reset values: all outputs 0; key_valid 0; state IDLE; counters 0.
- `rst` mid-operation: returns to IDLE on the next edge and clears the key; any pending `des_done` is ignored.
- 8th payload byte `rx_valid` at cycle N:
  - 'E'/'D': `des_start` at N+2.
  - 'K': `des_key` updated at N+1, `tx_start` at N+2 if `tx_busy`=0.
- `des_done` at cycle M: first `tx_start` at M+2 at the earliest.
- Back-to-back `tx_start` pulses are at least 3 cycles apart and never asserted while `tx_busy`=1.
- `des_done` outside DES_WAIT: ignored.
- `rx_valid` and timeout expiry in the same cycle: the byte wins and the timeout counter clears.

## Test plan
- Key load: send 'K', then 01 23 45 67 89 AB CD EF → `des_key`=0123456789ABCDEF, status[0]=1, one tx byte 0x06.
- Encrypt (DES stub returns data^key after 16 cycles): after the key above, send 'E' 63 6F 6D 70 75 74 65 72 → exactly one `des_start`, `des_decrypt`=0, tx bytes 62 4C 28 17 FC DF A8 9D in order.
- Decrypt with no key after reset: send 'D' + 8 bytes → no `des_start`, tx 0xEE, status[2]=1.
- Illegal command 0x41 in IDLE → status[2]=1, no tx output. A following valid 'K' frame clears status[2] and completes normally.
- Timeout: with `TIMEOUT`=100, send 'E' + 3 bytes, then idle 150 cycles → back to IDLE, status[2]=1, no `des_start`. Next frame accepted normally.
- Overflow and reset: an extra byte during DES_WAIT sets status[3] and the result is still sent intact. Asserting `rst` during TX_WAIT returns all outputs to 0 and no further `tx_start` occurs.
